pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, flush and deterministic NOP bubbles. It replaces the hand-written inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block carrying a flat payload vector of configurable width. An optional two-entry skid buffer registers the backpressure path. Stall becomes backpressure: a stalled consumer deasserts `out_ready`, and an upstream with nothing to send deasserts `in_valid`, which produces a NOP bubble.

---
 rtl/pipe_stage_reg.sv | 117 +++++++++++
 tb/tb_pipe_stage_reg.sv | 106 ++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush, NOP bubbles and a
// saturating bubble counter. Define PIPE_STAGE_SKID_EN to build the two-entry skid variant.
module pipe_stage_reg #(
  parameter int unsigned        DATA_W    = 64,
  parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}},
  parameter int unsigned        CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              m_v_q, m_v_d;
  logic [DATA_W-1:0] m_d_q, m_d_d;
  logic [CNT_W-1:0]  bub_q, bub_d;
  logic              xfer_in, xfer_out;

  assign out_valid  = m_v_q;
  assign out_data   = m_d_q;
  assign bubble_cnt = bub_q;
  assign xfer_in    = in_valid & in_ready;
  assign xfer_out   = m_v_q & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              s_v_q, s_v_d;
  logic [DATA_W-1:0] s_d_q, s_d_d;

  // Ready comes straight from the skid flop, breaking the out_ready -> in_ready path.
  assign in_ready = ~s_v_q;

  always_comb begin
    m_v_d = m_v_q;
    m_d_d = m_d_q;
    s_v_d = s_v_q;
    s_d_d = s_d_q;
    if (flush) begin
      m_v_d = 1'b0;
      m_d_d = NOP_VALUE;
      s_v_d = 1'b0;
      s_d_d = NOP_VALUE;
    end else if (xfer_out) begin
      if (s_v_q) begin
        m_v_d = 1'b1;
        m_d_d = s_d_q;
        s_v_d = xfer_in;
        s_d_d = xfer_in ? in_data : NOP_VALUE;
      end else begin
        m_v_d = xfer_in;
        m_d_d = xfer_in ? in_data : NOP_VALUE;
      end
    end else if (xfer_in) begin
      if (m_v_q) begin
        s_v_d = 1'b1;
        s_d_d = in_data;
      end else begin
        m_v_d = 1'b1;
        m_d_d = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_v_q <= 1'b0;
      s_d_q <= NOP_VALUE;
    end else begin
      s_v_q <= s_v_d;
      s_d_q <= s_d_d;
    end
  end
`else
  assign in_ready = ~m_v_q | out_ready;

  always_comb begin
    m_v_d = m_v_q;
    m_d_d = m_d_q;
    if (flush) begin
      m_v_d = 1'b0;
      m_d_d = NOP_VALUE;
    end else if (xfer_in) begin
      // Covers both a fill and an in-place replace alongside an out transfer.
      m_v_d = 1'b1;
      m_d_d = in_data;
    end else if (xfer_out) begin
      m_v_d = 1'b0;
      m_d_d = NOP_VALUE;
    end
  end
`endif

  // Flush does not gate the counter; it only tracks the bubble condition.
  always_comb begin
    bub_d = bub_q;
    if (~m_v_q & out_ready & (bub_q != {CNT_W{1'b1}}))
      bub_d = bub_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_v_q <= 1'b0;
      m_d_q <= NOP_VALUE;
      bub_q <= '0;
    end else begin
      m_v_q <= m_v_d;
      m_d_q <= m_d_d;
      bub_q <= bub_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised scoreboard bench for pipe_stage_reg: a FIFO-occupancy model predicts
// outputs, in_ready and the bubble counter every cycle.
module tb_pipe_stage_reg;
  localparam int          DW  = 64;
  localparam logic [63:0] NOP = 64'h1;
  localparam int          CW  = 4;
`ifdef PIPE_STAGE_SKID_EN
  localparam int          CAP = 2;
`else
  localparam int          CAP = 1;
`endif

  logic          clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] bubble_cnt;

  pipe_stage_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb[$];
  int  bub   = 0;
  bit  armed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: check current outputs against the model, then advance the model
  // by what will happen at the coming rising edge (inputs are stable here).
  always @(negedge clk) begin
    bit exp_rdy;
    if (CAP == 2) exp_rdy = (sb.size() < 2);
    else          exp_rdy = (sb.size() == 0) || out_ready;
    if (armed) begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, sb.size() > 0});
      chk("out_data", out_data, (sb.size() > 0) ? sb[0] : NOP);
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
      chk("bubble_cnt", {60'd0, bubble_cnt}, 64'(bub));
    end
    if (rst) begin
      sb.delete();
      bub   = 0;
      armed = 1;
    end else if (armed) begin
      if (sb.size() == 0 && out_ready && bub < (1 << CW) - 1) bub++;
      if (flush) sb.delete();
      else begin
        if (sb.size() > 0 && out_ready) void'(sb.pop_front());
        if (in_valid && exp_rdy) sb.push_back(in_data);
      end
    end
  end

  task automatic cyc(input bit r, input bit f, input bit iv, input logic [DW-1:0] d, input bit ordy);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; in_data = '0; out_ready = 1;
    // Reset, then streaming
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 64'hA0 + 64'(i), 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    // Backpressure mid-stream
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 64'hC0 + 64'(i), (i < 3 || i > 6));
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    // Fill, then flush while 0xB5 is offered
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 64'hD0 + 64'(i), 0);
    cyc(0, 1, 1, 64'hB5, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    // Bubble counter saturation, flush, reset
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // Random traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 3) != 0), {$urandom, $urandom},
          ($urandom_range(0, 2) != 0));
    cyc(0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
